// File: rtl/vjtag_bridge_if.sv
// rtl/vjtag_bridge_if.sv - host-side register bus between the JTAG bridge and the register file
interface vjtag_bridge_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] address;
  logic              addr_we;
  logic [DATA_W-1:0] data_out;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] data_in;
  logic              rd_valid;

  modport master (
    output address, addr_we, data_out, we, re,
    input  data_in, rd_valid
  );

  modport slave (
    input  address, addr_we, data_out, we, re,
    output data_in, rd_valid
  );
endinterface

// File: rtl/vjtag_bridge.sv
// rtl/vjtag_bridge.sv - Virtual JTAG DR scans to host register bus, with burst, prefetch hold and status
module vjtag_bridge #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int IR_W   = 3
) (
  input  logic            tck,
  input  logic            init_n,
  input  logic            tdi,
  input  logic [IR_W-1:0] ir_in,
  input  logic            v_cdr,
  input  logic            v_sdr,
  input  logic            v_udr,
  output logic            tdo,
  vjtag_bridge_if.master  bus
);

  typedef enum logic [2:0] {
    CMD_BYPASS   = 3'd0,
    CMD_ADDR     = 3'd1,
    CMD_PUSH     = 3'd2,
    CMD_POP      = 3'd3,
    CMD_PUSH_INC = 3'd4,
    CMD_POP_INC  = 3'd5,
    CMD_STATUS   = 3'd6,
    CMD_SOFT_RST = 3'd7
  } cmd_e;

  cmd_e cmd;
  logic upper_nz;

  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              we_q, we_d;
  logic              we_inc_q, we_inc_d;
  logic              addr_we_q, addr_we_d;
  logic              re_q, re_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic              underrun_q, underrun_d;
  logic              overrun_q, overrun_d;
  logic [4:0]        wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] ar_sh_q, ar_sh_d;
  logic [DATA_W-1:0] dr_sh_q, dr_sh_d;
  logic [DATA_W-1:0] out_sh_q, out_sh_d;
  logic [7:0]        st_sh_q, st_sh_d;
  logic              pop_cap;

  // Any set bit above the 3-bit opcode demotes the command to BYPASS.
  always_comb begin
    upper_nz = 1'b0;
    for (int i = 3; i < IR_W; i++) begin
      upper_nz = upper_nz | ir_in[i];
    end
    cmd = upper_nz ? CMD_BYPASS : cmd_e'(ir_in[2:0]);
  end

  assign pop_cap = v_cdr && (cmd == CMD_POP || cmd == CMD_POP_INC);

  always_comb begin
    address_d    = address_q;
    data_out_d   = data_out_q;
    we_d         = 1'b0;
    we_inc_d     = 1'b0;
    addr_we_d    = 1'b0;
    re_d         = 1'b0;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    underrun_d   = underrun_q;
    overrun_d    = overrun_q;
    wr_cnt_d     = wr_cnt_q;
    ar_sh_d      = ar_sh_q;
    dr_sh_d      = dr_sh_q;
    out_sh_d     = out_sh_q;
    st_sh_d      = st_sh_q;

    // Write bookkeeping lands on the edge that closes the we cycle.
    if (we_q) begin
      wr_cnt_d = wr_cnt_q + 5'd1;
      if (we_inc_q) address_d = address_q + ADDR_W'(1);
    end

    if (v_sdr) begin
      case (cmd)
        CMD_ADDR: begin
          ar_sh_d = ar_sh_q >> 1;
          ar_sh_d[ADDR_W-1] = tdi;
        end
        CMD_PUSH, CMD_PUSH_INC: begin
          dr_sh_d = dr_sh_q >> 1;
          dr_sh_d[DATA_W-1] = tdi;
        end
        CMD_POP, CMD_POP_INC: begin
          out_sh_d = out_sh_q >> 1;
          out_sh_d[DATA_W-1] = tdi;
        end
        CMD_STATUS: st_sh_d = {tdi, st_sh_q[7:1]};
        default: ;
      endcase
    end

    if (v_cdr) begin
      case (cmd)
        CMD_POP, CMD_POP_INC: begin
          if (hold_valid_q) begin
            out_sh_d     = hold_q;
            hold_valid_d = 1'b0;
          end else begin
            out_sh_d   = '0;
            underrun_d = 1'b1;
          end
          if (cmd == CMD_POP_INC) address_d = address_q + ADDR_W'(1);
          re_d = 1'b1;
        end
        CMD_STATUS: st_sh_d = {wr_cnt_q, overrun_q, underrun_q, hold_valid_q};
        default: ;
      endcase
    end

    if (v_udr) begin
      case (cmd)
        CMD_ADDR: begin
          address_d    = ar_sh_q;
          hold_valid_d = 1'b0;
          addr_we_d    = 1'b1;
          re_d         = 1'b1;
        end
        CMD_PUSH, CMD_PUSH_INC: begin
          data_out_d = dr_sh_q;
          we_d       = 1'b1;
          we_inc_d   = (cmd == CMD_PUSH_INC);
        end
        CMD_STATUS: begin
          underrun_d = 1'b0;
          overrun_d  = 1'b0;
        end
        default: ;
      endcase
    end

    // A returning read beats any clear of hold_valid on the same edge.
    if (bus.rd_valid) begin
      hold_d       = bus.data_in;
      hold_valid_d = 1'b1;
      if (hold_valid_q && !pop_cap) overrun_d = 1'b1;
    end

    if (v_udr && cmd == CMD_SOFT_RST) begin
      address_d    = '0;
      data_out_d   = '0;
      we_d         = 1'b0;
      we_inc_d     = 1'b0;
      addr_we_d    = 1'b0;
      re_d         = 1'b0;
      hold_d       = '0;
      hold_valid_d = 1'b0;
      underrun_d   = 1'b0;
      overrun_d    = 1'b0;
      wr_cnt_d     = '0;
      ar_sh_d      = '0;
      dr_sh_d      = '0;
      out_sh_d     = '0;
      st_sh_d      = '0;
    end
  end

  always_ff @(posedge tck or negedge init_n) begin
    if (!init_n) begin
      address_q    <= '0;
      data_out_q   <= '0;
      we_q         <= 1'b0;
      we_inc_q     <= 1'b0;
      addr_we_q    <= 1'b0;
      re_q         <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
      wr_cnt_q     <= '0;
      ar_sh_q      <= '0;
      dr_sh_q      <= '0;
      out_sh_q     <= '0;
      st_sh_q      <= '0;
    end else begin
      address_q    <= address_d;
      data_out_q   <= data_out_d;
      we_q         <= we_d;
      we_inc_q     <= we_inc_d;
      addr_we_q    <= addr_we_d;
      re_q         <= re_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      underrun_q   <= underrun_d;
      overrun_q    <= overrun_d;
      wr_cnt_q     <= wr_cnt_d;
      ar_sh_q      <= ar_sh_d;
      dr_sh_q      <= dr_sh_d;
      out_sh_q     <= out_sh_d;
      st_sh_q      <= st_sh_d;
    end
  end

  always_comb begin
    case (cmd)
      CMD_ADDR:               tdo = ar_sh_q[0];
      CMD_PUSH, CMD_PUSH_INC: tdo = dr_sh_q[0];
      CMD_POP, CMD_POP_INC:   tdo = out_sh_q[0];
      CMD_STATUS:             tdo = st_sh_q[0];
      default:                tdo = tdi;
    endcase
  end

  assign bus.address  = address_q;
  assign bus.addr_we  = addr_we_q;
  assign bus.data_out = data_out_q;
  assign bus.we       = we_q;
  assign bus.re       = re_q;

endmodule

// File: tb/tb_vjtag_bridge.sv
// tb/tb_vjtag_bridge.sv - directed scans with queued expectations checked by a bus/scan monitor
module tb_vjtag_bridge;
  logic       tck = 1'b0;
  logic       init_n = 1'b0;
  logic       tdi = 1'b0;
  logic [2:0] ir_in = 3'd0;
  logic       v_cdr = 1'b0, v_sdr = 1'b0, v_udr = 1'b0;
  logic       tdo;

  vjtag_bridge_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  vjtag_bridge #(.DATA_W(8), .ADDR_W(8), .IR_W(3)) dut (
    .tck(tck), .init_n(init_n), .tdi(tdi), .ir_in(ir_in),
    .v_cdr(v_cdr), .v_sdr(v_sdr), .v_udr(v_udr), .tdo(tdo), .bus(bus)
  );

  always #5 tck = ~tck;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_awe[$];
  logic [7:0]  exp_re[$];
  logic [15:0] exp_we[$];
  logic [7:0]  exp_tdo[$];

  logic [7:0] scan_word = 8'h00;
  int         scan_cnt = 0;
  int         scan_seen = 0;
  logic       man_v = 1'b0;
  logic [7:0] man_d = 8'h00;
  logic       model_en = 1'b0;
  logic [1:0] pipe_v = 2'b00;
  logic [7:0] pipe_d0 = 8'h00, pipe_d1 = 8'h00;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_empty(input string name, input int n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events never seen", name, n);
    end
  endtask

  // Read-side model: returns address ^ 0xA5 two cycles after re, or a manual injection.
  initial begin
    bus.rd_valid = 1'b0;
    bus.data_in  = 8'h00;
    forever begin
      @(negedge tck);
      #1;
      bus.rd_valid = pipe_v[1] | man_v;
      bus.data_in  = man_v ? man_d : pipe_d1;
      pipe_v[1] = pipe_v[0];
      pipe_d1   = pipe_d0;
      pipe_v[0] = model_en & bus.re;
      pipe_d0   = bus.address ^ 8'hA5;
    end
  end

  // Monitor: every bus strobe and every completed scan pops one expectation.
  initial begin
    forever begin
      @(negedge tck);
      #2;
      if (init_n) begin
        if (bus.addr_we) begin
          if (exp_awe.size() == 0) chk("addr_we_unexpected", 16'd1, 16'd0);
          else chk("addr_we_address", {8'h00, bus.address}, {8'h00, exp_awe.pop_front()});
        end
        if (bus.re) begin
          if (exp_re.size() == 0) chk("re_unexpected", 16'd1, 16'd0);
          else chk("re_address", {8'h00, bus.address}, {8'h00, exp_re.pop_front()});
        end
        if (bus.we) begin
          if (exp_we.size() == 0) chk("we_unexpected", 16'd1, 16'd0);
          else chk("we_addr_data", {bus.address, bus.data_out}, exp_we.pop_front());
        end
        if (scan_cnt != scan_seen) begin
          scan_seen = scan_cnt;
          if (exp_tdo.size() == 0) chk("scan_unexpected", 16'd1, 16'd0);
          else chk("scan_tdo_word", {8'h00, scan_word}, {8'h00, exp_tdo.pop_front()});
        end
      end
    end
  end

  task automatic scan(input logic [2:0] ir, input int w, input logic [7:0] val,
                      input logic do_chk, input logic [7:0] exp,
                      input logic inj, input logic [7:0] inj_d);
    logic [7:0] word;
    word = 8'h00;
    if (do_chk) exp_tdo.push_back(exp);
    @(negedge tck);
    ir_in = ir;
    v_cdr = 1'b1;
    if (inj) begin
      man_v = 1'b1;
      man_d = inj_d;
    end
    for (int i = 0; i < w; i++) begin
      @(negedge tck);
      v_cdr = 1'b0;
      man_v = 1'b0;
      v_sdr = 1'b1;
      tdi   = val[i];
      #1;
      word[i] = tdo;
    end
    @(negedge tck);
    v_sdr = 1'b0;
    v_udr = 1'b1;
    tdi   = 1'b0;
    @(negedge tck);
    v_udr = 1'b0;
    if (do_chk) begin
      scan_word = word;
      scan_cnt++;
    end
    repeat (4) @(negedge tck);
  endtask

  task automatic pulse_rv(input logic [7:0] d);
    @(negedge tck);
    man_v = 1'b1;
    man_d = d;
    @(negedge tck);
    man_v = 1'b0;
    repeat (2) @(negedge tck);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random TAP activity
    for (int i = 0; i < 6; i++) begin
      @(negedge tck);
      ir_in = 3'($urandom);
      {v_cdr, v_sdr, v_udr} = 3'($urandom);
      tdi = 1'($urandom);
      #2;
      chk("reset_outputs", {bus.address, 3'b000, bus.we, bus.re, bus.addr_we, 2'b00},
          16'h0000);
      chk("reset_data_out", {8'h00, bus.data_out}, 16'h0000);
    end
    @(negedge tck);
    {v_cdr, v_sdr, v_udr} = 3'b000;
    tdi = 1'b0;
    ir_in = 3'd0;
    @(negedge tck);
    init_n = 1'b1;
    repeat (2) @(negedge tck);
    scan(3'd6, 8, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00);

    // Underrun: POP with nothing held, then sticky status and its clear
    exp_re.push_back(8'h00);
    scan(3'd3, 8, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00);
    scan(3'd6, 8, 8'h00, 1'b1, 8'h02, 1'b0, 8'h00);
    scan(3'd6, 8, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00);

    // Overrun: two reads land with no POP between them
    pulse_rv(8'h11);
    pulse_rv(8'h22);
    scan(3'd6, 8, 8'h00, 1'b1, 8'h05, 1'b0, 8'h00);

    // ADDR then PUSH
    exp_awe.push_back(8'h5A);
    exp_re.push_back(8'h5A);
    scan(3'd1, 8, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00);
    exp_we.push_back({8'h5A, 8'hC3});
    scan(3'd2, 8, 8'hC3, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("push_address_kept", {8'h00, bus.address}, 16'h005A);

    scan(3'd7, 1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("softrst1_address", {8'h00, bus.address}, 16'h0000);
    chk("softrst1_data_out", {8'h00, bus.data_out}, 16'h0000);

    // Burst write across the address wrap
    exp_awe.push_back(8'hFE);
    exp_re.push_back(8'hFE);
    scan(3'd1, 8, 8'hFE, 1'b0, 8'h00, 1'b0, 8'h00);
    exp_we.push_back({8'hFE, 8'h01});
    scan(3'd4, 8, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00);
    exp_we.push_back({8'hFF, 8'h02});
    scan(3'd4, 8, 8'h02, 1'b0, 8'h00, 1'b0, 8'h00);
    exp_we.push_back({8'h00, 8'h03});
    scan(3'd4, 8, 8'h03, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("burst_final_address", {8'h00, bus.address}, 16'h0001);
    scan(3'd6, 8, 8'h00, 1'b1, 8'h18, 1'b0, 8'h00);

    // Burst read with prefetch model
    model_en = 1'b1;
    exp_awe.push_back(8'h10);
    exp_re.push_back(8'h10);
    scan(3'd1, 8, 8'h10, 1'b0, 8'h00, 1'b0, 8'h00);
    exp_re.push_back(8'h11);
    scan(3'd5, 8, 8'h00, 1'b1, 8'hB5, 1'b0, 8'h00);
    exp_re.push_back(8'h12);
    scan(3'd5, 8, 8'h00, 1'b1, 8'hB4, 1'b0, 8'h00);
    exp_re.push_back(8'h13);
    scan(3'd5, 8, 8'h00, 1'b1, 8'hB7, 1'b0, 8'h00);
    repeat (4) @(negedge tck);
    model_en = 1'b0;

    // rd_valid coincident with POP capture
    exp_awe.push_back(8'h00);
    exp_re.push_back(8'h00);
    scan(3'd1, 8, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    exp_re.push_back(8'h00);
    scan(3'd3, 8, 8'h00, 1'b1, 8'h00, 1'b1, 8'h77);
    exp_re.push_back(8'h00);
    scan(3'd3, 8, 8'h00, 1'b1, 8'h77, 1'b0, 8'h00);

    // Soft reset from a busy state
    exp_awe.push_back(8'h33);
    exp_re.push_back(8'h33);
    scan(3'd1, 8, 8'h33, 1'b0, 8'h00, 1'b0, 8'h00);
    exp_we.push_back({8'h33, 8'h44});
    scan(3'd4, 8, 8'h44, 1'b0, 8'h00, 1'b0, 8'h00);
    pulse_rv(8'h99);
    chk("pre_softrst_address", {8'h00, bus.address}, 16'h0034);
    scan(3'd7, 1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("softrst2_address", {8'h00, bus.address}, 16'h0000);
    scan(3'd6, 8, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00);

    repeat (4) @(negedge tck);
    chk_empty("pending_addr_we", exp_awe.size());
    chk_empty("pending_re", exp_re.size());
    chk_empty("pending_we", exp_we.size());
    chk_empty("pending_scan", exp_tdo.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vjtag_bridge.md
# vjtag_bridge

- Parametrised successor to the 8-bit virtual-JTAG register-access bridge.
- Converts Virtual JTAG TAP-state strobes into a host-side register bus with configurable data and address widths.
- Adds auto-incrementing burst read/write, a read-prefetch hold register with a valid handshake, a sticky status word, and a JTAG-commanded soft reset.
- Sits between the `vjtag_interface` megafunction wrapper, which drives the TAP inputs, and the design's register file or memory.

## Interface
- `DATA_W`, default 8: data word width; must be ≥ 1.
- `ADDR_W`, default 8: address width; must be ≥ 1.
- `IR_W`, default 3: virtual IR width; must be ≥ 3.
- `tck` in 1: JTAG clock; the only clock.
- `init_n` in 1: asynchronous, active-low reset.
- `tdi` in 1: serial data in.
- `ir_in` in IR_W: current virtual IR command.
- `v_cdr`, `v_sdr`, `v_udr` in 1 each: Capture-DR, Shift-DR and Update-DR state flags.
- `tdo` out 1: serial data out.
- `address` out ADDR_W: bus address.
- `addr_we` out 1: one-cycle pulse, address loaded.
- `data_out` out DATA_W: write data.
- `we` out 1: one-cycle write strobe.
- `re` out 1: one-cycle read request for `address`.
- `data_in` in DATA_W: read data.
- `rd_valid` in 1: `data_in` valid this cycle.

## Operation
- IR codes are decoded on `ir_in[2:0]`; upper bits must be 0, otherwise the command is treated as BYPASS.
- Codes: 0 BYPASS, 1 ADDR, 2 PUSH, 3 POP, 4 PUSH_INC, 5 POP_INC, 6 STATUS, 7 SOFT_RST.
- All shifts are LSB first: `sh <= {tdi, sh[W-1:1]}` on each `tck` with `v_sdr` and a matching IR.
- **ADDR**
  - Shifts `ar_sh` (ADDR_W).
  - `v_udr` edge: `address <= ar_sh`, `hold_valid <= 0`.
  - Next cycle: `addr_we = 1` and `re = 1`; this is the prefetch read.
- **PUSH / PUSH_INC**
  - Shifts `dr_sh` (DATA_W).
  - `v_udr` edge: `data_out <= dr_sh`.
  - Next cycle: `we = 1` with the unchanged `address`.
  - PUSH_INC only: at the edge ending the `we` cycle, `address <= address + 1`, modulo 2^ADDR_W, with no `addr_we`.
  - `wr_cnt` (5 bit, wraps) increments per `we` pulse.
- **POP / POP_INC**
  - `v_cdr` edge, hold valid: `out_sh <= hold`, `hold_valid <= 0`.
  - `v_cdr` edge, hold not valid: `out_sh <= 0`, sticky `underrun <= 1`.
  - On the same `v_cdr` edge, POP_INC increments `address`.
  - `re = 1` in the following cycle, at the resulting `address`.
  - `v_sdr` shifts `out_sh`.
- **Hold register**
  - On `rd_valid`: `hold <= data_in`, `hold_valid <= 1`.
  - If `hold_valid` was already 1 and no POP capture happens at that edge, sticky `overrun <= 1`.
- **STATUS**
  - `v_cdr` edge: `st_sh <= {wr_cnt[4:0], overrun, underrun, hold_valid}`, 8 bits, with `hold_valid` in bit 0.
  - `v_sdr` shifts `st_sh`.
  - `v_udr` edge clears `underrun` and `overrun`.
- **SOFT_RST**: a `v_udr` edge synchronously applies the full reset state.
- **tdo**: combinational mux of the shift-register LSB:
  - ADDR → `ar_sh[0]`
  - PUSH / PUSH_INC → `dr_sh[0]`
  - POP / POP_INC → `out_sh[0]`
  - STATUS → `st_sh[0]`
  - otherwise → `tdi`
- A strobe with a non-matching IR has no effect.

## Timing
- **Reset values** (`init_n` low, asynchronous): every register and output is 0, i.e. `address`, `data_out`, `we`, `addr_we`, `re`, `hold`, `hold_valid`, the sticky flags, `wr_cnt` and all shift registers. `tdo` follows the mux.
- **Pulse latencies**: `we`, `addr_we` and `re` are registered. Each is exactly 1 cycle wide, asserted in the cycle after the triggering `v_udr` / `v_cdr` edge.
- **Read latency** is unconstrained. `rd_valid` may arrive any number of cycles after `re`; the data is only delivered if it lands before the next POP capture.
- **`rd_valid` coincident with POP `v_cdr`**:
  - Capture uses the pre-edge `hold` / `hold_valid`.
  - The new data loads `hold`, and `hold_valid` ends at 1, because the load wins over the clear.
  - No overrun is flagged.
- **`rd_valid` coincident with ADDR `v_udr`**: the load wins and `hold_valid` ends at 1.
- **Address wrap**: all-ones + 1 = 0, for both INC commands.
- **Mutual exclusion**: `v_cdr`, `v_sdr` and `v_udr` are mutually exclusive by TAP definition; the bridge does not arbitrate them.
- **`init_n` mid-shift**: partial shift contents are discarded. The next scan must start from Capture-DR.

## Test plan
- **Reset**: `init_n` low with random `ir_in`/strobes → all outputs 0. Release, then STATUS scan → `tdo` stream 0x00.
- **ADDR + PUSH, DATA_W=8, ADDR_W=8**:
  - Stimulus: ADDR scan 0x5A, then PUSH scan 0xC3.
  - Response: `addr_we` and `re` pulse 1 cycle after ADDR `v_udr`, with `address` = 0x5A.
  - Response: `we` pulse 1 cycle with `data_out` = 0xC3, `address` still 0x5A.
- **Burst write**:
  - Stimulus: ADDR 0xFE, then PUSH_INC ×3 with data 1, 2, 3.
  - Response: `we` at addresses 0xFE, 0xFF, 0x00; final `address` = 0x01.
  - Response: STATUS `wr_cnt` = 3.
- **Burst read**:
  - Stimulus: ADDR 0x10; a model returns `rd_valid` with `data_in` = `address` ^ 0xA5, 2 cycles after each `re`; then POP_INC ×3.
  - Response: shifted-out words 0xB5, 0xB4, 0xB7.
  - Response: `re` addresses 0x10, 0x11, 0x12, 0x13.
- **Underrun / overrun**:
  - Stimulus: POP with no `rd_valid` pending.
  - Response: shifts out 0x00; STATUS reads 0x02, then after its `v_udr` a second STATUS reads 0x00.
  - Stimulus: two `rd_valid` pulses without a POP.
  - Response: STATUS bit 2 set.
- **Coincidence + soft reset**:
  - Stimulus: `rd_valid` 0x77 on the same edge as POP `v_cdr` with `hold_valid` = 0.
  - Response: that POP shifts out 0x00; the next POP shifts out 0x77.
  - Stimulus: SOFT_RST `v_udr`.
  - Response: `address` = 0, `wr_cnt` = 0, `hold_valid` = 0.
